inst_constraint: RTL and testbench
==================================

Name: inst_constraint

Overview:
- Instruction-legality monitor for the QED decode stage of the SPARC V9 core.
- Decodes the instruction presented at decode (`ifu_buf0_inst0`) and classifies it against the QED-duplicable subset: branches/SETHI, integer ALU ops, and loads/stores confined to the original register half r0–r15.
- Provides combinational legality flags for the formal environment.
- Provides registered violation reporting (flag, sticky, counter, capture) for simulation and debug.

Parameters:
- REG_LIMIT, 16: register indices must be strictly less than this value; indices REG_LIMIT and above belong to the QED duplicate half.
- CNT_W, 16: width of the violation counter.

Ports:
- clk, input, 1: decode clock (core `l2clk`).
- rst, input, 1: synchronous active-high reset.
- dec_valid_d, input, 1: the instruction at decode is valid this cycle.
- instruction, input, 32: instruction word at decode.
- allowed_op0, output, 1: combinational; format-2 instruction is legal.
- allowed_op2, output, 1: combinational; arithmetic instruction is legal.
- allowed_op3, output, 1: combinational; load/store instruction is legal.
- allowed, output, 1: combinational; OR of the three flags above.
- violation, output, 1: registered; pulses one cycle after an illegal valid instruction.
- violation_sticky, output, 1: registered; set on the first violation, held until reset.
- viol_count, output, CNT_W: registered; saturating count of violations.
- last_bad_inst, output, 32: registered; most recent illegal valid instruction.

Behaviour:
- Field extraction:
  - op = instruction[31:30]
  - rd = [29:25]
  - op2 = [24:22]
  - op3 = [24:19]
  - rs1 = [18:14]
  - i = [13]
  - rs2 = [4:0]
- Register rule `regs_ok`, all of the following:
  - rd < REG_LIMIT
  - rs1 < REG_LIMIT
  - either i=1 (rs2 field ignored), or i=0 and rs2 < REG_LIMIT
- allowed_op0 = (op==00) and op2 in {001 BPcc, 010 Bicc, 011 BPr, 100 SETHI/NOP}. There are no register restrictions for op0.
- allowed_op2 = (op==10) and regs_ok and op3 in:
  - 0x00–0x0C: ADD, AND, OR, XOR, SUB, ANDN, ORN, XNOR, ADDC, MULX, UMUL, SMUL, SUBC
  - 0x10–0x18: the cc variants ADDcc through ADDCcc
  - 0x1A, 0x1B, 0x1C: UMULcc, SMULcc, SUBCcc
  - All other op3 values are illegal, including 0x0D, 0x0E, 0x0F, 0x19 and everything ≥0x1D.
- allowed_op3 = (op==11) and regs_ok. Any op3 is accepted.
- op==01 (CALL) is always illegal.
- The flags are purely combinational and independent of dec_valid_d and rst.
- Registered path, updated on the posedge clk:
  - rst=1: violation=0, violation_sticky=0, viol_count=0, last_bad_inst=0. Reset has priority over a simultaneous bad instruction.
  - Else, if dec_valid_d=1 and allowed=0:
    - violation=1
    - violation_sticky=1
    - viol_count increments, saturating at all-ones
    - last_bad_inst is loaded with instruction
  - Else: violation=0; the other registers hold.
- Latency: exactly 1 cycle from the illegal instruction to the violation pulse. Back-to-back illegal instructions keep violation high and count once per cycle.
- X on instruction is not filtered; the environment guarantees known values.

Test Plan:
- NOP 0x01000000 with dec_valid_d=1 → allowed_op0=1, allowed=1; next cycle violation=0, viol_count=0.
- ADD r1,r2,r3 = 0x82008003 → allowed_op2=1. Load 0xC2008003 → allowed_op3=1. Neither causes a violation.
- ADD with rd=r17 (0xA2008003), valid → allowed=0; next cycle violation=1, viol_count=1, last_bad_inst=0xA2008003, sticky=1.
- Immediate form with rs2 field=19 (0x82006013) → allowed=1. UDIVX op3=0x0D (0x82688003) → allowed=0.
- CALL 0x40000000 with dec_valid_d=0 → allowed=0 and no violation. Same word with valid=1 for 3 cycles → violation high for 3 cycles, viol_count=3.
- Assert rst in the same cycle as an illegal valid instruction → all registered outputs 0. Drive count to all-ones → it holds, no wrap.

Source files
------------

// File: rtl/inst_constraint_if.sv
// Decode-stage bus between the instruction source and the QED legality monitor.
interface inst_constraint_if #(
    parameter int unsigned CNT_W = 16
);
    logic             dec_valid_d;
    logic [31:0]      instruction;
    logic             allowed_op0;
    logic             allowed_op2;
    logic             allowed_op3;
    logic             allowed;
    logic             violation;
    logic             violation_sticky;
    logic [CNT_W-1:0] viol_count;
    logic [31:0]      last_bad_inst;

    // Decode side: presents instructions, observes legality and violation state.
    modport master (
        output dec_valid_d, instruction,
        input  allowed_op0, allowed_op2, allowed_op3, allowed,
        input  violation, violation_sticky, viol_count, last_bad_inst
    );

    // Monitor side.
    modport slave (
        input  dec_valid_d, instruction,
        output allowed_op0, allowed_op2, allowed_op3, allowed,
        output violation, violation_sticky, viol_count, last_bad_inst
    );
endinterface

// File: rtl/inst_constraint.sv
// QED instruction-legality monitor: classifies the decode instruction against the
// duplicable subset (branches/SETHI, integer ALU, r0-r15 loads/stores) and records
// violations for debug.
module inst_constraint #(
    parameter int unsigned REG_LIMIT = 16,
    parameter int unsigned CNT_W     = 16
) (
    input logic               clk,
    input logic               rst,
    inst_constraint_if.slave  bus
);

    logic [1:0] op;
    logic [4:0] rd;
    logic [2:0] op2;
    logic [5:0] op3;
    logic [4:0] rs1;
    logic       immSel;
    logic [4:0] rs2;
    logic       regsOk;
    logic       op3Arith;

    // Field extraction and register-half rule.
    always_comb begin
        op     = bus.instruction[31:30];
        rd     = bus.instruction[29:25];
        op2    = bus.instruction[24:22];
        op3    = bus.instruction[24:19];
        rs1    = bus.instruction[18:14];
        immSel = bus.instruction[13];
        rs2    = bus.instruction[4:0];
        regsOk = (32'(rd) < REG_LIMIT) && (32'(rs1) < REG_LIMIT) &&
                 (immSel || (32'(rs2) < REG_LIMIT));
    end

    // Integer ALU op3 whitelist; divides, tagged ops and everything above SUBCcc are excluded.
    always_comb begin
        op3Arith = 1'b0;
        case (op3) inside
            [6'h00:6'h0C]: op3Arith = 1'b1;
            [6'h10:6'h18]: op3Arith = 1'b1;
            [6'h1A:6'h1C]: op3Arith = 1'b1;
            default:       op3Arith = 1'b0;
        endcase
    end

    // Combinational legality flags, independent of valid and reset.
    always_comb begin
        bus.allowed_op0 = (op == 2'b00) && (op2 >= 3'b001) && (op2 <= 3'b100);
        bus.allowed_op2 = (op == 2'b10) && regsOk && op3Arith;
        bus.allowed_op3 = (op == 2'b11) && regsOk;
        bus.allowed     = bus.allowed_op0 || bus.allowed_op2 || bus.allowed_op3;
    end

    // Violation pulse, sticky flag, saturating counter and capture of the offending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.violation        <= 1'b0;
            bus.violation_sticky <= 1'b0;
            bus.viol_count       <= '0;
            bus.last_bad_inst    <= '0;
        end else if (bus.dec_valid_d && !bus.allowed) begin
            bus.violation        <= 1'b1;
            bus.violation_sticky <= 1'b1;
            if (bus.viol_count != '1) begin
                bus.viol_count <= bus.viol_count + CNT_W'(1);
            end
            bus.last_bad_inst    <= bus.instruction;
        end else begin
            bus.violation        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_constraint.sv
// Bench for inst_constraint: directed cases followed by random instructions, checked
// against an arithmetic model of the legality rules. A second instance with a 4-bit
// counter exercises saturation.
module tb_inst_constraint;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    inst_constraint_if #(.CNT_W(16)) bus ();
    inst_constraint_if #(.CNT_W(4))  busSmall ();

    inst_constraint #(.REG_LIMIT(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    inst_constraint #(.REG_LIMIT(16), .CNT_W(4)) dutSmall (
        .clk (clk),
        .rst (rst),
        .bus (busSmall.slave)
    );

    always #5 clk = ~clk;

    // Reference state for the registered outputs.
    bit          mViol;
    bit          mSticky;
    int unsigned mCount;
    int unsigned mCountSmall;
    logic [31:0] mLast;

    int unsigned arithOps[$] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                 6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17,
                                 6'h18, 6'h1A, 6'h1B, 6'h1C};

    function automatic bit isArith(input int unsigned code);
        foreach (arithOps[k]) if (arithOps[k] == code) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model(input logic [31:0] w, output bit a0, output bit a2, output bit a3);
        int unsigned word = w;
        int unsigned op   = word / (1 << 30);
        int unsigned rd   = (word / (1 << 25)) % 32;
        int unsigned op2  = (word / (1 << 22)) % 8;
        int unsigned op3  = (word / (1 << 19)) % 64;
        int unsigned rs1  = (word / (1 << 14)) % 32;
        int unsigned imm  = (word / (1 << 13)) % 2;
        int unsigned rs2  = word % 32;
        bit regsOk = (rd < 16) && (rs1 < 16) && (imm == 1 || rs2 < 16);
        a0 = (op == 0) && (op2 >= 1) && (op2 <= 4);
        a2 = (op == 2) && regsOk && isArith(op3);
        a3 = (op == 3) && regsOk;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One decode cycle: drive, check flags, clock, check registered outputs.
    task automatic step(input logic v, input logic [31:0] w, input logic r);
        bit a0, a2, a3, al;
        rst                  = r;
        bus.dec_valid_d      = v;
        bus.instruction      = w;
        busSmall.dec_valid_d = v;
        busSmall.instruction = w;
        model(w, a0, a2, a3);
        al = a0 | a2 | a3;
        #1;
        check("allowed_op0", 64'(bus.allowed_op0), 64'(a0));
        check("allowed_op2", 64'(bus.allowed_op2), 64'(a2));
        check("allowed_op3", 64'(bus.allowed_op3), 64'(a3));
        check("allowed",     64'(bus.allowed),     64'(al));
        check("allowed_small", 64'(busSmall.allowed), 64'(al));
        if (r) begin
            mViol = 0; mSticky = 0; mCount = 0; mCountSmall = 0; mLast = '0;
        end else if (v && !al) begin
            mViol = 1; mSticky = 1;
            if (mCount < 65535) mCount++;
            if (mCountSmall < 15) mCountSmall++;
            mLast = w;
        end else begin
            mViol = 0;
        end
        @(posedge clk);
        #1;
        check("violation",        64'(bus.violation),        64'(mViol));
        check("violation_sticky", 64'(bus.violation_sticky), 64'(mSticky));
        check("viol_count",       64'(bus.viol_count),       64'(mCount));
        check("last_bad_inst",    64'(bus.last_bad_inst),    64'(mLast));
        check("viol_count_small", 64'(busSmall.viol_count),  64'(mCountSmall));
    endtask

    initial begin
        logic [31:0] w;
        logic        v;
        logic        r;

        rst = 1'b1;
        bus.dec_valid_d = 1'b0;      bus.instruction = '0;
        busSmall.dec_valid_d = 1'b0; busSmall.instruction = '0;
        @(negedge clk);

        // Reset state.
        step(1'b0, 32'h0100_0000, 1'b1);
        check("reset_count_const", 64'(bus.viol_count), 64'd0);

        // Legal NOP, ADD, load.
        step(1'b1, 32'h0100_0000, 1'b0);
        check("nop_no_violation", 64'(bus.violation), 64'd0);
        step(1'b1, 32'h8200_8003, 1'b0);
        step(1'b1, 32'hC200_8003, 1'b0);
        check("legal_count_const", 64'(bus.viol_count), 64'd0);

        // ADD with rd=r17.
        step(1'b1, 32'hA200_8003, 1'b0);
        check("r17_violation_const", 64'(bus.violation), 64'd1);
        check("r17_count_const", 64'(bus.viol_count), 64'd1);
        check("r17_last_const", 64'(bus.last_bad_inst), 64'hA200_8003);
        check("r17_sticky_const", 64'(bus.violation_sticky), 64'd1);

        // Immediate form ignores rs2 field; UDIVX is rejected.
        step(1'b1, 32'h8200_6013, 1'b0);
        check("imm_sticky_held", 64'(bus.violation_sticky), 64'd1);
        step(1'b1, 32'h8268_8003, 1'b0);
        check("udivx_count_const", 64'(bus.viol_count), 64'd2);

        // CALL while invalid, then reset, then three valid CALLs back-to-back.
        step(1'b0, 32'h4000_0000, 1'b0);
        check("call_invalid_no_pulse", 64'(bus.violation), 64'd0);
        step(1'b0, 32'h0100_0000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h4000_0000, 1'b0);
            check("call_pulse_const", 64'(bus.violation), 64'd1);
        end
        check("call_count_const", 64'(bus.viol_count), 64'd3);

        // Reset wins over a simultaneous illegal instruction.
        step(1'b1, 32'h4000_0000, 1'b1);
        check("rst_prio_violation", 64'(bus.violation), 64'd0);
        check("rst_prio_count", 64'(bus.viol_count), 64'd0);

        // Small counter saturates without wrapping.
        for (int k = 0; k < 20; k++) step(1'b1, 32'h4000_0000, 1'b0);
        check("sat_small_const", 64'(busSmall.viol_count), 64'd15);
        check("sat_big_const", 64'(bus.viol_count), 64'd20);

        // Random instructions, biased toward the legal register half and ALU/memory ops.
        for (int n = 0; n < 400; n++) begin
            w = $urandom();
            if ($urandom_range(0, 1) == 1) w = w & 32'hDFFB_FFEF;
            if ($urandom_range(0, 2) != 0) w[31] = 1'b1;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 63) == 0);
            step(v, w, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
